serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller. It sequences a single full-adder cell, built from two half-adder gates, over WIDTH cycles to add two WIDTH-bit operands. Operands arrive through a valid/ready request port, and results leave through a valid/ready response port. It sits between a requesting datapath and the shared 1-bit adder resource, trading latency for area.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  operands a/b are valid.
- req_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, sampled on handshake.
- b  in  WIDTH  operand B, sampled on handshake.
- rsp_valid  out  1  sum/carry_out are valid.
- rsp_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a+b modulo 2^WIDTH.
- carry_out  out  1  carry out of bit WIDTH-1.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: load a into the A shift register and b into the B shift register; clear the carry register, bit counter and sum register; go to RUN.
- RUN:
  - req_ready=0.
  - Each cycle the full-adder cell takes LSB(A), LSB(B) and the carry register:
    - s = A0^B0^c.
    - co = (A0&B0)|((A0^B0)&c).
  - Then: A and B shift right by 1; s shifts into sum at MSB (sum shifts right); the carry register takes co; the counter increments.
  - When counter==WIDTH-1 on a processed cycle, go to DONE. The counter does not wrap.
- DONE:
  - rsp_valid=1.
  - sum and carry_out are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
- req_valid while not in IDLE is ignored; operands are not captured.
- rsp_ready outside DONE is ignored.
- Arithmetic: {carry_out,sum} = a+b, computed unsigned at WIDTH+1 bits.
- Counter width: $clog2(WIDTH).
- sum and carry_out keep their last result in IDLE until the next load clears them.

## Timing
- Reset (asynchronous, rst_n=0):
  - State=IDLE; sum=0; carry_out=0; rsp_valid=0; req_ready=1 once rst_n is released.
  - The counter, shift registers and carry register are all cleared.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No response is produced.
- Request handshake at edge 0:
  - Edges 1..WIDTH process bits 0..WIDTH-1.
  - rsp_valid rises after edge WIDTH.
  - Minimum latency is WIDTH+1 edges from acceptance to rsp_valid.
- Response handshake at edge k: req_ready=1 after edge k. There is no same-cycle response-to-request overlap, so the minimum initiation interval is WIDTH+2 cycles.
- Inputs a/b may change freely after the request handshake.
- rsp_valid, once high, stays high with unchanged data until accepted.

## Structure
- Shared package serial_adder_pkg:
  - state enum (IDLE, RUN, DONE, 2-bit encoding).
  - default WIDTH constant.
- Sub-module fa_from_ha: 1-bit full adder made from two half-adder gate instances (xor/and) plus an OR for carry. serial_adder_ctrl instantiates exactly one.
- Remaining logic lives in the top module: FSM, counter, shift registers, carry register.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, rsp_ready=1 → rsp_valid after 9 edges from acceptance; sum=0x96, carry_out=0.
- a=0xFF, b=0x01 → sum=0x00, carry_out=1. Then a=0x00, b=0x00 → sum=0x00, carry_out=0; confirms the carry register is cleared on load.
- Hold rsp_ready=0 for 5 cycles in DONE with a=0x80, b=0x80 → rsp_valid stays 1; sum=0x00 and carry_out=1 stable throughout; IDLE one edge after rsp_ready=1.
- Pulse req_valid with a=0x11, b=0x22 during RUN of a=0x01, b=0x02 → req_ready=0 and the second request is ignored; result sum=0x03.
- Drop rst_n in the 4th RUN cycle → sum=0, carry_out=0, rsp_valid=0 immediately. After release, a=0x7F, b=0x01 → sum=0x80, carry_out=0.
- 1000 random operand pairs with random rsp_ready gaps, WIDTH=8 and WIDTH=32 → every {carry_out,sum} equals a+b; no lost or duplicated responses.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder controller
package serial_adder_pkg;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the bit counter for a given operand width (never below 1 bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_from_ha.sv
// rtl/fa_from_ha.sv - 1-bit full adder built from two half-adder gates and an OR
module ha_gate (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module fa_from_ha (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g0;
  logic g1;

  // First stage combines the operand bits, second stage folds in the carry.
  ha_gate u_ha0 (
    .x (a),
    .y (b),
    .s (p),
    .c (g0)
  );

  ha_gate u_ha1 (
    .x (p),
    .y (ci),
    .s (s),
    .c (g1)
  );

  // Either stage generating a carry produces the carry out.
  assign co = g0 | g1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencing one full-adder cell over WIDTH cycles
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;

  assign accept   = req_valid && req_ready;
  assign last_bit = (cnt == LAST);

  // The single shared full-adder cell always looks at the operand LSBs and the carry register.
  fa_from_ha u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH bit-cycles, hold the result until taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs depend only on the current state.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operands on acceptance, then shift one bit per RUN cycle; result holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      carry  <= fa_co;
      if (!last_bit) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign sum       = sum_sr;
  assign carry_out = carry;

endmodule
